strobe_sequencer: RTL

//  Controller for the divide-by-N data-valid strobe path.
//  - Accepts a start request with a period and burst length.
//  - Runs an internal period counter and emits one-cycle dv pulses.
//  - Stops after the programmed number of pulses, or on an explicit stop.
//  - Sits between the lab control logic (buttons/FSM) and any consumer of dv.

---
 rtl/strobe_seq_pkg.sv | 13 +
 rtl/period_counter.sv | 28 ++
 rtl/strobe_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/strobe_seq_pkg.sv
// rtl/strobe_seq_pkg.sv - shared state encoding and default widths for the strobe sequencer
package strobe_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W_DEF   = 8;
  localparam int BURST_W_DEF = 8;

endpackage

// File: rtl/period_counter.sv
// rtl/period_counter.sv - loadable down-counter with zero flag; load has priority over enable
module period_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at zero so an enabled but unreloaded counter never wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/strobe_sequencer.sv
// rtl/strobe_sequencer.sv - divide-by-N data-valid strobe burst controller
// STROBE_SEQ_CONTINUOUS_EN: burst_len of 0 runs continuously until stop instead of one pulse.
module strobe_sequencer
  import strobe_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [CNT_W-1:0]   i_period,
  input  logic [BURST_W-1:0] i_burst_len,
  output logic               o_dv,
  output logic               o_busy,
  output logic               o_done,
  output logic [BURST_W-1:0] o_pulse_cnt
);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_dv;
  logic [BURST_W-1:0] r_pulse_cnt;
  logic [BURST_W-1:0] r_burst;
  logic [CNT_W-1:0]   r_period_m1;

  logic               w_accept;
  logic               w_fire;
  logic               w_last;
  logic               w_zero;
  logic               w_cnt_load;
  logic [CNT_W-1:0]   w_cnt_load_val;
  logic [CNT_W-1:0]   w_period_m1_in;
  logic [BURST_W-1:0] w_burst_in;
  logic [BURST_W-1:0] w_pulse_inc;

  // A zero period behaves as a period of one.
  assign w_period_m1_in = (i_period == '0) ? '0 : (i_period - CNT_W'(1));
  assign w_pulse_inc    = r_pulse_cnt + BURST_W'(1);

`ifdef STROBE_SEQ_CONTINUOUS_EN
  assign w_burst_in = i_burst_len;
  assign w_last     = (r_burst != '0) && (w_pulse_inc == r_burst);
`else
  assign w_burst_in = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
  assign w_last     = (w_pulse_inc == r_burst);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Stop is tested before the counter so it suppresses a coincident pulse.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_fire       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          w_accept     = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_next_state = ST_IDLE;
        end else if (w_zero) begin
          w_fire = 1'b1;
          if (w_last) begin
            w_next_state = ST_DONE;
          end
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dv        <= 1'b0;
      r_pulse_cnt <= '0;
      r_burst     <= '0;
      r_period_m1 <= '0;
    end else begin
      r_dv <= w_fire;
      if (w_accept) begin
        r_pulse_cnt <= '0;
        r_burst     <= w_burst_in;
        r_period_m1 <= w_period_m1_in;
      end else if (w_fire) begin
        r_pulse_cnt <= w_pulse_inc;
      end
    end
  end

  assign w_cnt_load     = w_accept | w_fire;
  assign w_cnt_load_val = w_accept ? w_period_m1_in : r_period_m1;

  period_counter #(
    .CNT_W(CNT_W)
  ) u_period_counter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_en       (r_state == ST_RUN),
    .o_zero     (w_zero)
  );

  assign o_dv        = r_dv;
  assign o_busy      = (r_state == ST_RUN);
  assign o_done      = (r_state == ST_DONE);
  assign o_pulse_cnt = r_pulse_cnt;

endmodule
